// File: rtl/mdu_div_pkg.sv
// mdu_div shared definitions: MDU control codes
// and divider FSM state encodings.
package mdu_div_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b00100;
  localparam logic [4:0] MULTU_CONTROL = 5'b00101;
  localparam logic [4:0] DIV_CONTROL   = 5'b00110;
  localparam logic [4:0] DIVU_CONTROL  = 5'b00111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(
    input logic [4:0] ctl
  );
    return (ctl == DIV_CONTROL) ||
           (ctl == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring division iteration.
// Shifts {rem, quot} left and conditionally subtracts.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  assign rem_sh = {rem_i, quot_i[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, divisor_i};

  // keep the difference when it is non-negative, else restore
  always_comb begin
    rem_o  = rem_sh[WIDTH:0];
    quot_o = {quot_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_o  = trial[WIDTH:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_div.sv
// mdu_div: multi-cycle radix-2 restoring divider
// for MIPS DIV/DIVU, result {remainder, quotient}.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         MDUControl,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] DivResult
);

  import mdu_div_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               sgn_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   qfix;
  logic [WIDTH-1:0]   rfix;

  assign sgn_op = (MDUControl == DIV_CONTROL);
  assign a_neg  = sgn_op & A[WIDTH-1];
  assign b_neg  = sgn_op & B[WIDTH-1];
  assign a_mag  = a_neg ? (~A + 1'b1) : A;
  assign b_mag  = b_neg ? (~B + 1'b1) : B;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  // remainder sign restore also yields raw A on divide by zero
  assign rfix = negr_q ? (~rem_q[WIDTH-1:0] + 1'b1)
                       : rem_q[WIDTH-1:0];
  assign qfix = div0_q ? {WIDTH{1'b1}}
              : (negq_q ? (~quot_q + 1'b1) : quot_q);

  assign busy      = (state_q == DIV_CALC) ||
                     (state_q == DIV_FIX);
  assign done      = (state_q == DIV_DONE);
  assign DivResult = res_q;

  // next-state, operand latch, iteration and sign fix
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    res_d   = res_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start && is_div_op(MDUControl) && !cancel) begin
          state_d = DIV_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quot_d  = a_mag;
          dvsr_d  = b_mag;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          div0_d  = (B == '0);
        end
      end
      DIV_CALC: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else begin
          res_d   = {rfix, qfix};
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: randomized and directed checks of mdu_div
// against a cycle-timeline arithmetic reference model.
module tb_mdu_div;
  import mdu_div_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [4:0]    ctl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic          busy;
  logic          done;
  logic [2*W-1:0] res;

  int checks;
  int failures;

  mdu_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .MDUControl(ctl),
    .A         (a),
    .B         (b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .DivResult (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // plain arithmetic reference: truncating division
  function automatic logic [63:0] ref_div(
    input bit sgn,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx;
    longint sy;
    longint q;
    longint r;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // timeline model: age = cycles since the accepted start
  int          age;
  logic [63:0] pend_res;
  logic [63:0] exp_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age     <= 0;
      exp_res <= '0;
    end else if (age == 0) begin
      if (start && !cancel &&
          (ctl == DIV_CONTROL || ctl == DIVU_CONTROL)) begin
        age      <= 1;
        pend_res <= ref_div(ctl == DIV_CONTROL, a, b);
      end
    end else if (age <= W + 1) begin
      if (cancel) begin
        age <= 0;
      end else begin
        age <= age + 1;
        if (age == W + 1) exp_res <= pend_res;
      end
    end else begin
      age <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("mdl_busy", {63'h0, busy},
          {63'h0, (age >= 1 && age <= W + 1)});
      chk("mdl_done", {63'h0, done},
          {63'h0, (age == W + 2)});
      chk("mdl_result", res, exp_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] c,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int cancel_at,
                        output logic [63:0] r,
                        output int lat);
    ctl = c;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    r = '0;
    for (int k = 1; k <= 45; k++) begin
      if (done) begin
        lat = k;
        r = res;
        break;
      end
      if (k == cancel_at) cancel = 1'b1;
      tick();
      cancel = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    logic [4:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] r;
  logic [63:0] prev;
  int          lat;
  int          ndone;
  int          first;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    ctl = DIVU_CONTROL;
    a = '0;
    b = '0;
    cancel = 1'b0;
    #12;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_result", res, 64'h0);
    rst = 1'b1;
    tick();

    vecs[0] = '{DIVU_CONTROL, 32'd100, 32'd7,
                64'h00000002_0000000E};
    vecs[1] = '{DIV_CONTROL, 32'hFFFFFFF9, 32'd2,
                64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{DIV_CONTROL, 32'd7, 32'hFFFFFFFE,
                64'h00000001_FFFFFFFD};
    vecs[3] = '{DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF,
                64'h00000000_80000000};
    vecs[4] = '{DIVU_CONTROL, 32'd5, 32'd0,
                64'h00000005_FFFFFFFF};
    vecs[5] = '{DIV_CONTROL, 32'hFFFFFFF9, 32'd0,
                64'hFFFFFFF9_FFFFFFFF};
    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].x, vecs[i].y, 0, r, lat);
      chk($sformatf("dir%0d_lat", i), 64'(lat), 64'd34);
      chk($sformatf("dir%0d_res", i), r, vecs[i].e);
      tick();
    end

    // cancel mid-CALC, then restart two cycles later
    prev = res;
    ctl = DIVU_CONTROL;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {63'h0, busy}, 64'h0);
    chk("cancel_keep", res, prev);
    tick();
    a = 32'hFFFFFFFF;
    b = 32'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first = 0;
    r = '0;
    for (int k = 13; k <= 50; k++) begin
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          r = res;
        end
      end
      tick();
    end
    chk("cancel_ndone", 64'(ndone), 64'd1);
    chk("cancel_lat", 64'(first), 64'd46);
    chk("cancel_res", r, 64'h0000000F_0FFFFFFF);

    // start during busy must be ignored
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first = 0;
    r = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
      end
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          r = res;
        end
      end
      tick();
      start = 1'b0;
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lat", 64'(first), 64'd34);
    chk("ign_res", r, 64'h00000002_0000000E);

    // non-divide control and cancel-with-start
    ctl = MULT_CONTROL;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mult_busy", {63'h0, busy}, 64'h0);
    tick();
    chk("mult_busy2", {63'h0, busy}, 64'h0);
    ctl = DIVU_CONTROL;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    chk("cstart_busy", {63'h0, busy}, 64'h0);
    tick();

    // asynchronous reset mid-CALC
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_result", res, 64'h0);
    #3;
    rst = 1'b1;
    tick();
    run_op(DIVU_CONTROL, 32'd9, 32'd3, 0, r, lat);
    chk("post_lat", 64'(lat), 64'd34);
    chk("post_res", r, 64'h00000000_00000003);
    tick();

    // randomized operations, some cancelled
    for (int n = 0; n < 120; n++) begin
      int ca;
      logic [4:0] c;
      logic [31:0] x;
      logic [31:0] y;
      c = $urandom_range(0, 1) ? DIV_CONTROL : DIVU_CONTROL;
      x = pick();
      y = pick();
      ca = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 33) : 0;
      run_op(c, x, y, ca, r, lat);
      if (ca == 0) begin
        chk("rnd_lat", 64'(lat), 64'd34);
        chk("rnd_res", r, ref_div(c == DIV_CONTROL, x, y));
      end else begin
        chk("rnd_cancel", 64'(lat), 64'd0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
